// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters with
// round-robin arbitration and a one-entry registered response slot each.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid_*/req_ready_*   request handshake (ready is combinational)
//   req_op_*/req_a_*/req_b_*  opcode and operands
//   rsp_valid_*/rsp_ready_*   response handshake
//   rsp_data_*/rsp_err_*      registered result and illegal-opcode flag
//   conflict_cnt              saturating count of cycles with both eligible
module alu_arbiter #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid_0,
   output logic             req_ready_0,
   input  logic [3:0]       req_op_0,
   input  logic [XLEN-1:0]  req_a_0,
   input  logic [XLEN-1:0]  req_b_0,
   input  logic             req_valid_1,
   output logic             req_ready_1,
   input  logic [3:0]       req_op_1,
   input  logic [XLEN-1:0]  req_a_1,
   input  logic [XLEN-1:0]  req_b_1,
   output logic             rsp_valid_0,
   input  logic             rsp_ready_0,
   output logic [XLEN-1:0]  rsp_data_0,
   output logic             rsp_err_0,
   output logic             rsp_valid_1,
   input  logic             rsp_ready_1,
   output logic [XLEN-1:0]  rsp_data_1,
   output logic             rsp_err_1,
   output logic [CNT_W-1:0] conflict_cnt
);

   localparam int unsigned SHW = $clog2(XLEN);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b1000;
   localparam logic [3:0] OP_SLL  = 4'b0001;
   localparam logic [3:0] OP_SLT  = 4'b0010;
   localparam logic [3:0] OP_SLTU = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_SRA  = 4'b1101;
   localparam logic [3:0] OP_OR   = 4'b0110;
   localparam logic [3:0] OP_AND  = 4'b0111;

   logic             prio_q, prio_d;
   logic             vld0_q, vld0_d, vld1_q, vld1_d;
   logic [XLEN-1:0]  dat0_q, dat0_d, dat1_q, dat1_d;
   logic             err0_q, err0_d, err1_q, err1_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             elig0, elig1, gnt0, gnt1;
   logic [3:0]       alu_op;
   logic [XLEN-1:0]  alu_a, alu_b, alu_out;
   logic             alu_illegal;
   logic [SHW-1:0]   shamt;

   // Eligibility, round-robin grant and ALU input mux
   always_comb begin
      elig0  = req_valid_0 && (!vld0_q || rsp_ready_0);
      elig1  = req_valid_1 && (!vld1_q || rsp_ready_1);
      gnt0   = 1'b0;
      gnt1   = 1'b0;
      if (!rst) begin
         if (elig0 && elig1) begin
            gnt0 = !prio_q;
            gnt1 = prio_q;
         end else begin
            gnt0 = elig0;
            gnt1 = elig1;
         end
      end
      alu_op = OP_ADD;
      alu_a  = '0;
      alu_b  = '0;
      if (gnt0) begin
         alu_op = req_op_0;
         alu_a  = req_a_0;
         alu_b  = req_b_0;
      end else if (gnt1) begin
         alu_op = req_op_1;
         alu_a  = req_a_1;
         alu_b  = req_b_1;
      end
   end

   // Shared ALU; illegal encodings produce zero
   always_comb begin
      shamt       = alu_b[SHW-1:0];
      alu_out     = '0;
      alu_illegal = 1'b0;
      case (alu_op)
         OP_ADD:  alu_out = alu_a + alu_b;
         OP_SUB:  alu_out = alu_a - alu_b;
         OP_SLL:  alu_out = alu_a << shamt;
         OP_SLT:  alu_out = XLEN'($signed(alu_a) < $signed(alu_b));
         OP_SLTU: alu_out = XLEN'(alu_a < alu_b);
         OP_XOR:  alu_out = alu_a ^ alu_b;
         OP_SRL:  alu_out = alu_a >> shamt;
         OP_SRA:  alu_out = XLEN'($signed(alu_a) >>> shamt);
         OP_OR:   alu_out = alu_a | alu_b;
         OP_AND:  alu_out = alu_a & alu_b;
         default: alu_illegal = 1'b1;
      endcase
   end

   // Next state of response slots, priority and conflict counter
   always_comb begin
      prio_d = prio_q;
      vld0_d = vld0_q;
      dat0_d = dat0_q;
      err0_d = err0_q;
      vld1_d = vld1_q;
      dat1_d = dat1_q;
      err1_d = err1_q;
      cnt_d  = cnt_q;
      // A grant on a slot being drained overwrites it and keeps it valid
      if (gnt0) begin
         vld0_d = 1'b1;
         dat0_d = alu_out;
         err0_d = alu_illegal;
      end else if (rsp_ready_0) begin
         vld0_d = 1'b0;
      end
      if (gnt1) begin
         vld1_d = 1'b1;
         dat1_d = alu_out;
         err1_d = alu_illegal;
      end else if (rsp_ready_1) begin
         vld1_d = 1'b0;
      end
      if (gnt0) prio_d = 1'b1;
      else if (gnt1) prio_d = 1'b0;
      if (elig0 && elig1 && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prio_q <= 1'b0;
         vld0_q <= 1'b0;
         dat0_q <= '0;
         err0_q <= 1'b0;
         vld1_q <= 1'b0;
         dat1_q <= '0;
         err1_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         prio_q <= prio_d;
         vld0_q <= vld0_d;
         dat0_q <= dat0_d;
         err0_q <= err0_d;
         vld1_q <= vld1_d;
         dat1_q <= dat1_d;
         err1_q <= err1_d;
         cnt_q  <= cnt_d;
      end
   end

   assign req_ready_0  = gnt0;
   assign req_ready_1  = gnt1;
   assign rsp_valid_0  = vld0_q;
   assign rsp_data_0   = dat0_q;
   assign rsp_err_0    = err0_q;
   assign rsp_valid_1  = vld1_q;
   assign rsp_data_1   = dat1_q;
   assign rsp_err_1    = err1_q;
   assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter: reset, conflict, ALU ops, backpressure,
// illegal opcode and reset while a response is pending.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid_0, req_valid_1, req_ready_0, req_ready_1;
   logic [3:0]  req_op_0, req_op_1;
   logic [31:0] req_a_0, req_b_0, req_a_1, req_b_1;
   logic        rsp_valid_0, rsp_valid_1, rsp_ready_0, rsp_ready_1;
   logic [31:0] rsp_data_0, rsp_data_1;
   logic        rsp_err_0, rsp_err_1;
   logic [15:0] conflict_cnt;

   int checks = 0;
   int errors = 0;

   alu_arbiter #(.XLEN(32), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .req_valid_0(req_valid_0), .req_ready_0(req_ready_0),
      .req_op_0(req_op_0), .req_a_0(req_a_0), .req_b_0(req_b_0),
      .req_valid_1(req_valid_1), .req_ready_1(req_ready_1),
      .req_op_1(req_op_1), .req_a_1(req_a_1), .req_b_1(req_b_1),
      .rsp_valid_0(rsp_valid_0), .rsp_ready_0(rsp_ready_0),
      .rsp_data_0(rsp_data_0), .rsp_err_0(rsp_err_0),
      .rsp_valid_1(rsp_valid_1), .rsp_ready_1(rsp_ready_1),
      .rsp_data_1(rsp_data_1), .rsp_err_1(rsp_err_1),
      .conflict_cnt(conflict_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change and outputs are sampled here
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      req_valid_0 = 1'b1; req_valid_1 = 1'b1;
      req_op_0 = 4'b0000; req_a_0 = '0; req_b_0 = '0;
      req_op_1 = 4'b0000; req_a_1 = '0; req_b_1 = '0;
      rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;

      // Reset held two cycles with both requesting
      tick();
      chk("rst_rdy0_c1", 32'(req_ready_0), 32'd0);
      chk("rst_rdy1_c1", 32'(req_ready_1), 32'd0);
      tick();
      chk("rst_rdy0_c2", 32'(req_ready_0), 32'd0);
      chk("rst_rdy1_c2", 32'(req_ready_1), 32'd0);

      // Release; conflict: r0 SUB 5-7, r1 SRA 0x80000000>>>4
      rst = 1'b0;
      req_op_0 = 4'b1000; req_a_0 = 32'd5; req_b_0 = 32'd7;
      req_op_1 = 4'b1101; req_a_1 = 32'h8000_0000; req_b_1 = 32'd4;
      #1;
      chk("post_rst_vld0", 32'(rsp_valid_0), 32'd0);
      chk("post_rst_vld1", 32'(rsp_valid_1), 32'd0);
      chk("post_rst_cnt", 32'(conflict_cnt), 32'd0);
      chk("first_gnt_rdy0", 32'(req_ready_0), 32'd1);
      chk("first_gnt_rdy1", 32'(req_ready_1), 32'd0);
      tick();
      chk("sub_vld0", 32'(rsp_valid_0), 32'd1);
      chk("sub_data0", rsp_data_0, 32'hFFFF_FFFE);
      chk("sub_err0", 32'(rsp_err_0), 32'd0);
      chk("conflict_1", 32'(conflict_cnt), 32'd1);
      req_valid_0 = 1'b0;
      #1;
      chk("sra_rdy1", 32'(req_ready_1), 32'd1);
      tick();
      chk("sra_vld1", 32'(rsp_valid_1), 32'd1);
      chk("sra_data1", rsp_data_1, 32'hF800_0000);
      chk("conflict_still_1", 32'(conflict_cnt), 32'd1);
      chk("drain_vld0", 32'(rsp_valid_0), 32'd0);

      // SLT on r0 and SLTU on r1 with a=-1, b=0; both eligible, prio=0
      req_valid_0 = 1'b1; req_op_0 = 4'b0010; req_a_0 = 32'hFFFF_FFFF; req_b_0 = 32'd0;
      req_valid_1 = 1'b1; req_op_1 = 4'b0011; req_a_1 = 32'hFFFF_FFFF; req_b_1 = 32'd0;
      #1;
      chk("slt_rdy0", 32'(req_ready_0), 32'd1);
      chk("slt_rdy1", 32'(req_ready_1), 32'd0);
      tick();
      chk("slt_data0", rsp_data_0, 32'd1);
      req_valid_0 = 1'b0;
      #1;
      chk("sltu_rdy1", 32'(req_ready_1), 32'd1);
      tick();
      chk("sltu_data1", rsp_data_1, 32'd0);
      chk("conflict_2", 32'(conflict_cnt), 32'd2);
      req_valid_1 = 1'b0;

      // Single requester: ADD overflow into sign bit
      req_valid_0 = 1'b1; req_op_0 = 4'b0000; req_a_0 = 32'h7FFF_FFFF; req_b_0 = 32'd1;
      #1;
      chk("add_rdy0", 32'(req_ready_0), 32'd1);
      tick();
      chk("add_vld0", 32'(rsp_valid_0), 32'd1);
      chk("add_data0", rsp_data_0, 32'h8000_0000);
      chk("add_err0", 32'(rsp_err_0), 32'd0);
      req_valid_0 = 1'b0;

      // Load r1 slot with 1+2 = 3
      req_valid_1 = 1'b1; req_op_1 = 4'b0000; req_a_1 = 32'd1; req_b_1 = 32'd2;
      #1;
      chk("load1_rdy1", 32'(req_ready_1), 32'd1);
      tick();
      chk("load1_data1", rsp_data_1, 32'd3);

      // Backpressure r1 for 5 cycles while r0 streams i+1
      rsp_ready_1 = 1'b0;
      req_op_1 = 4'b0100; req_a_1 = 32'h0000_00FF; req_b_1 = 32'h0000_000F;
      req_valid_0 = 1'b1; req_op_0 = 4'b0000; req_b_0 = 32'd1;
      for (int i = 0; i < 5; i++) begin
         req_a_0 = 32'(i) + 32'd10;
         #1;
         chk("bp_rdy1", 32'(req_ready_1), 32'd0);
         chk("bp_rdy0", 32'(req_ready_0), 32'd1);
         tick();
         chk("bp_hold_data1", rsp_data_1, 32'd3);
         chk("bp_hold_vld1", 32'(rsp_valid_1), 32'd1);
         chk("bp_stream_data0", rsp_data_0, 32'(i) + 32'd11);
      end
      req_valid_0 = 1'b0;
      rsp_ready_1 = 1'b1;
      #1;
      chk("bp_release_rdy1", 32'(req_ready_1), 32'd1);
      tick();
      chk("bp_release_vld1", 32'(rsp_valid_1), 32'd1);
      chk("bp_release_data1", rsp_data_1, 32'h0000_00F0);
      chk("bp_conflict", 32'(conflict_cnt), 32'd2);

      // Illegal opcode on r1, then a legal op clears the error
      req_op_1 = 4'b1111; req_a_1 = 32'hDEAD_BEEF; req_b_1 = 32'd1;
      #1;
      chk("ill_rdy1", 32'(req_ready_1), 32'd1);
      tick();
      chk("ill_data1", rsp_data_1, 32'd0);
      chk("ill_err1", 32'(rsp_err_1), 32'd1);
      req_op_1 = 4'b0000; req_a_1 = 32'd2; req_b_1 = 32'd3;
      tick();
      chk("legal_data1", rsp_data_1, 32'd5);
      chk("legal_err1", 32'(rsp_err_1), 32'd0);
      req_valid_1 = 1'b0;

      // Build prio=1 with r0 slot held, then reset mid-operation
      req_valid_0 = 1'b1; req_op_0 = 4'b0110; req_a_0 = 32'h0000_00F0; req_b_0 = 32'h0000_000F;
      tick();
      req_valid_0 = 1'b0;
      rsp_ready_0 = 1'b0;
      tick();
      chk("pend_vld0", 32'(rsp_valid_0), 32'd1);
      chk("pend_data0", rsp_data_0, 32'h0000_00FF);
      rst = 1'b1;
      req_valid_0 = 1'b1; req_valid_1 = 1'b1;
      #1;
      chk("midrst_rdy0", 32'(req_ready_0), 32'd0);
      chk("midrst_rdy1", 32'(req_ready_1), 32'd0);
      tick();
      chk("midrst_vld0", 32'(rsp_valid_0), 32'd0);
      chk("midrst_data0", rsp_data_0, 32'd0);
      chk("midrst_cnt", 32'(conflict_cnt), 32'd0);
      rst = 1'b0;
      rsp_ready_0 = 1'b1;
      #1;
      chk("midrst_prio_rdy0", 32'(req_ready_0), 32'd1);
      chk("midrst_prio_rdy1", 32'(req_ready_1), 32'd0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
